ulpi_link_ctrl: RTL and testbench
=================================

// Module: ulpi_link_ctrl
// PURPOSE
//  Link-side ULPI controller sitting between the USB core logic and an external ULPI PHY.
//  Sequences PHY start-up: holds o_rst, raises STP, waits for the PHY to assert DIR, then releases o_rst.
//  Afterwards it idles the bus (TX NOOP), tracks bus turnaround and receives RX data/RX CMD bytes.
//  Internal FSM register is named `state` (type ulpi_fsm_state_t) so benches can probe it hierarchically.
// PARAMETERS
//  STARTUP_TIMEOUT  65535  cycles in WAIT_DIR without i_dir before FSM restarts at RESET; 0 = never time out
// PORTS
//  i_clk   in   1  ULPI 60 MHz clock; the only clock
//  i_rst   in   1  asynchronous, active-low reset
//  i_dir   in   1  PHY DIR: 1 = PHY owns data bus
//  i_nxt   in   1  PHY NXT
//  o_stp   out  1  STP to PHY
//  o_rst   out  1  PHY reset, active-high
//  i_data  in   8  data bus from PHY
//  o_data  out  8  data bus to PHY
// BEHAVIOUR
//  All outputs registered. In reset: state=RESET, o_rst=1, o_stp=0, o_data=8'h00.
//  States (ulpi_fsm_state_t), transitions on i_clk rising edge:
//   RESET              -> RESET_SET_STP_HIGH unconditionally; o_rst=1
//   RESET_SET_STP_HIGH -> WAIT_DIR; o_stp<=1 on this transition; o_rst=1
//   WAIT_DIR   : o_stp=1, o_rst=1; if i_dir=1 -> WAIT_DIR_LOW with o_rst<=0 (same edge)
//                else count; count==STARTUP_TIMEOUT (if nonzero) -> RESET
//   WAIT_DIR_LOW: o_stp=1, o_rst=0; i_dir=0 -> IDLE with o_stp<=0
//   IDLE       : o_data=8'h00 (NOOP), o_stp=0; i_dir=1 -> RX_TURN
//   RX_TURN    : one turnaround cycle, i_data ignored; i_dir=1 -> RX, i_dir=0 -> IDLE
//   RX         : i_nxt=1 -> i_data is USB data; i_nxt=0 -> i_data is RX CMD; i_dir=0 -> TX_TURN
//   TX_TURN    : one turnaround cycle, o_data=0 -> IDLE (i_dir=1 -> RX_TURN)
//  Latency: o_rst falls on the first edge where i_dir=1 is seen in WAIT_DIR, i.e. >=3 edges after reset release.
//  o_stp rises on the 2nd edge after reset release.
//  i_dir=1 in RESET / RESET_SET_STP_HIGH has no effect; sequence always passes through WAIT_DIR.
//  Reset asserted mid-operation: immediate async return to RESET values from any state.
//  o_data driven only when i_dir=0; always 8'h00 in this revision (no TX CMD generation).
//  o_rst never re-asserts after start-up except via i_rst or a WAIT_DIR timeout.
// CONFIGURATION
//  ULPI_RXCMD_CAPTURE_EN defined: adds output o_rxcmd[7:0], updated with i_data in RX when i_nxt=0, reset 8'h00.
//   Also adds o_rxcmd_vld[0:0], a 1-cycle pulse on each update.
//  Not defined: ports absent; RX CMD bytes discarded.
// STRUCTURE
//  Package ulpi_pkg: typedef enum ulpi_fsm_state_t with ULPI_FSM_STATE_RESET, _RESET_SET_STP_HIGH, _WAIT_DIR,
//   _WAIT_DIR_LOW, _IDLE, _RX_TURN, _RX, _TX_TURN; localparam ULPI_TX_NOOP=8'h00.
//  Package ulpi_pkg is wildcard-imported at compilation-unit scope so enum literals are visible unscoped.
//  One sub-module natural: ulpi_startup_timer (timeout counter for WAIT_DIR). FSM and output regs stay in top.
// TESTING
//  Reset low, one clock edge -> state=RESET, o_rst=1, o_stp=0.
//  Release reset, i_dir=0, edge 1 -> state=RESET_SET_STP_HIGH, o_rst=1.
//  Edge 2 -> o_stp=1, o_rst=1.
//  i_dir=1, edge 3 -> o_rst=0.
//  Drop i_dir -> next edge state=IDLE, o_stp=0.
//  Start-up, then i_dir=1 for 3 cycles -> RX_TURN, RX.
//  Then i_dir=0 -> TX_TURN, IDLE; o_data=8'h00 throughout.
//  Reset released, i_dir held 0 with STARTUP_TIMEOUT=4 -> FSM returns to RESET after 4 WAIT_DIR cycles.
//  Reset asserted while in RX -> outputs immediately o_rst=1, o_stp=0, o_data=0.

Source files
------------

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared FSM state type and bus constants for the ULPI link controller
package ulpi_pkg;
  typedef enum logic [2:0] {
    ULPI_FSM_STATE_RESET,
    ULPI_FSM_STATE_RESET_SET_STP_HIGH,
    ULPI_FSM_STATE_WAIT_DIR,
    ULPI_FSM_STATE_WAIT_DIR_LOW,
    ULPI_FSM_STATE_IDLE,
    ULPI_FSM_STATE_RX_TURN,
    ULPI_FSM_STATE_RX,
    ULPI_FSM_STATE_TX_TURN
  } ulpi_fsm_state_t;
  localparam logic [7:0] ULPI_TX_NOOP = 8'h00;
endpackage

// File: rtl/ulpi_startup_timer.sv
// ulpi_startup_timer: counts cycles spent waiting for DIR; expire fires on the TIMEOUT-th cycle, never when TIMEOUT=0
module ulpi_startup_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= en ? cnt + 1'b1 : '0;
  assign expire = (TIMEOUT != 0) && en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: ULPI PHY start-up sequencing, bus turnaround tracking and RX reception.
// Optional ULPI_RXCMD_CAPTURE_EN adds o_rxcmd / o_rxcmd_vld capture of RX CMD bytes.
import ulpi_pkg::*;
module ulpi_link_ctrl #(
  parameter int unsigned STARTUP_TIMEOUT = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dir,
  input  logic       i_nxt,
  output logic       o_stp,
  output logic       o_rst,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
`ifdef ULPI_RXCMD_CAPTURE_EN
  ,
  output logic [7:0] o_rxcmd,
  output logic [0:0] o_rxcmd_vld
`endif
);
  ulpi_fsm_state_t state, nxt_state;
  logic expire;
  ulpi_startup_timer #(.TIMEOUT(STARTUP_TIMEOUT)) u_timer (
    .clk(i_clk),
    .rst_n(i_rst),
    .en(state == ULPI_FSM_STATE_WAIT_DIR),
    .expire(expire)
  );
  always_comb begin
    nxt_state = state;
    case (state)
      ULPI_FSM_STATE_RESET:              nxt_state = ULPI_FSM_STATE_RESET_SET_STP_HIGH;
      ULPI_FSM_STATE_RESET_SET_STP_HIGH: nxt_state = ULPI_FSM_STATE_WAIT_DIR;
      ULPI_FSM_STATE_WAIT_DIR:           nxt_state = i_dir ? ULPI_FSM_STATE_WAIT_DIR_LOW :
                                                     expire ? ULPI_FSM_STATE_RESET : ULPI_FSM_STATE_WAIT_DIR;
      ULPI_FSM_STATE_WAIT_DIR_LOW:       nxt_state = i_dir ? ULPI_FSM_STATE_WAIT_DIR_LOW : ULPI_FSM_STATE_IDLE;
      ULPI_FSM_STATE_IDLE:               nxt_state = i_dir ? ULPI_FSM_STATE_RX_TURN : ULPI_FSM_STATE_IDLE;
      ULPI_FSM_STATE_RX_TURN:            nxt_state = i_dir ? ULPI_FSM_STATE_RX : ULPI_FSM_STATE_IDLE;
      ULPI_FSM_STATE_RX:                 nxt_state = i_dir ? ULPI_FSM_STATE_RX : ULPI_FSM_STATE_TX_TURN;
      ULPI_FSM_STATE_TX_TURN:            nxt_state = i_dir ? ULPI_FSM_STATE_RX_TURN : ULPI_FSM_STATE_IDLE;
      default:                           nxt_state = ULPI_FSM_STATE_RESET;
    endcase
  end
  // Outputs are registered from the next state so they change on the same edge as the FSM
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state  <= ULPI_FSM_STATE_RESET;
      o_rst  <= 1'b1;
      o_stp  <= 1'b0;
      o_data <= ULPI_TX_NOOP;
    end else begin
      state  <= nxt_state;
      o_rst  <= nxt_state inside {ULPI_FSM_STATE_RESET, ULPI_FSM_STATE_RESET_SET_STP_HIGH, ULPI_FSM_STATE_WAIT_DIR};
      o_stp  <= nxt_state inside {ULPI_FSM_STATE_WAIT_DIR, ULPI_FSM_STATE_WAIT_DIR_LOW};
      o_data <= ULPI_TX_NOOP;
    end
`ifdef ULPI_RXCMD_CAPTURE_EN
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      o_rxcmd     <= 8'h00;
      o_rxcmd_vld <= 1'b0;
    end else begin
      o_rxcmd_vld <= (state == ULPI_FSM_STATE_RX) && !i_nxt;
      o_rxcmd     <= (state == ULPI_FSM_STATE_RX) && !i_nxt ? i_data : o_rxcmd;
    end
`endif
endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// tb_ulpi_link_ctrl: vector table plus scoreboard check of start-up, turnaround, timeout and async reset
import ulpi_pkg::*;
module tb_ulpi_link_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dir = 1'b0;
  logic nxt = 1'b0;
  logic [7:0] din = 8'h00;
  logic stp, prst;
  logic [7:0] dout;
`ifdef ULPI_RXCMD_CAPTURE_EN
  logic [7:0] rxcmd;
  logic [0:0] rxcmd_vld;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ulpi_link_ctrl #(.STARTUP_TIMEOUT(4)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_dir(dir),
    .i_nxt(nxt),
    .o_stp(stp),
    .o_rst(prst),
    .i_data(din),
    .o_data(dout)
`ifdef ULPI_RXCMD_CAPTURE_EN
    ,
    .o_rxcmd(rxcmd),
    .o_rxcmd_vld(rxcmd_vld)
`endif
  );

  typedef struct {
    logic            rst_n;
    logic            dir;
    logic            nxt;
    logic [7:0]      data;
    ulpi_fsm_state_t st;
    logic            prst;
    logic            stp;
  } vec_t;

  typedef struct {
    int              idx;
    ulpi_fsm_state_t st;
    logic            prst;
    logic            stp;
    logic [7:0]      data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic compare_out(input exp_t e);
    string tag;
    tag = $sformatf("v%0d", e.idx);
    chk({tag, "_state"}, 8'(dut.state), 8'(e.st));
    chk({tag, "_o_rst"}, 8'(prst), 8'(e.prst));
    chk({tag, "_o_stp"}, 8'(stp), 8'(e.stp));
    chk({tag, "_o_data"}, dout, e.data);
  endtask

  task automatic add(input logic r, input logic d, input logic n, input logic [7:0] x,
                     input ulpi_fsm_state_t s, input logic pr, input logic sp);
    vec_t v;
    v.rst_n = r; v.dir = d; v.nxt = n; v.data = x; v.st = s; v.prst = pr; v.stp = sp;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    // reset, start-up with DIR high already during RESET_SET_STP_HIGH
    add(0, 0, 0, 8'h00, ULPI_FSM_STATE_RESET,              1, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_RESET_SET_STP_HIGH, 1, 0);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR_LOW,       0, 1);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR_LOW,       0, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_IDLE,               0, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_IDLE,               0, 0);
    // receive: turnaround, data, RX CMD, back to IDLE
    add(1, 1, 0, 8'hFF, ULPI_FSM_STATE_RX_TURN,            0, 0);
    add(1, 1, 0, 8'h11, ULPI_FSM_STATE_RX,                 0, 0);
    add(1, 1, 1, 8'hAA, ULPI_FSM_STATE_RX,                 0, 0);
    add(1, 1, 0, 8'h5C, ULPI_FSM_STATE_RX,                 0, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_TX_TURN,            0, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_IDLE,               0, 0);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_RX_TURN,            0, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_IDLE,               0, 0);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_RX_TURN,            0, 0);
    add(1, 1, 1, 8'h33, ULPI_FSM_STATE_RX,                 0, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_TX_TURN,            0, 0);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_RX_TURN,            0, 0);
    // timeout after 4 WAIT_DIR cycles with DIR low
    add(0, 0, 0, 8'h00, ULPI_FSM_STATE_RESET,              1, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_RESET_SET_STP_HIGH, 1, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_RESET,              1, 0);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_RESET_SET_STP_HIGH, 1, 0);
    // DIR on the last WAIT_DIR cycle wins over the timeout
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR,           1, 1);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_WAIT_DIR_LOW,       0, 1);
    add(1, 0, 0, 8'h00, ULPI_FSM_STATE_IDLE,               0, 0);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_RX_TURN,            0, 0);
    add(1, 1, 0, 8'h00, ULPI_FSM_STATE_RX,                 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; dir = vecs[i].dir; nxt = vecs[i].nxt; din = vecs[i].data;
      e.idx = i; e.st = vecs[i].st; e.prst = vecs[i].prst; e.stp = vecs[i].stp; e.data = 8'h00;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("sb_empty", 8'd0, 8'd1);
      else compare_out(sb.pop_front());
      @(negedge clk);
    end

    // mid-RX reset must take effect before any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_state", 8'(dut.state), 8'(ULPI_FSM_STATE_RESET));
    chk("async_o_rst", 8'(prst), 8'd1);
    chk("async_o_stp", 8'(stp), 8'd0);
    chk("async_o_data", dout, 8'h00);
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
